// File: rtl/rot_pkg.sv
// Shared definitions for the rotation-engine job scheduler.
// Contents: image geometry, engine address field widths, pixel/counter
// widths and the scheduler state encoding.
package rot_pkg;

   localparam int IMG_DIM     = 28;
   localparam int PIX_PER_IMG = IMG_DIM * IMG_DIM;   // 784 pixels per job

   localparam int ROW_W  = 5;
   localparam int COL_W  = 5;
   localparam int ADDR_W = ROW_W + COL_W;            // engine address {row, col}
   localparam int PIX_W  = 8;
   localparam int CNT_W  = 10;                       // holds 0..783

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      RUN   = 2'd2
   } sched_state_t;

endpackage

// File: rtl/rot_job_sched_rr_arbiter.sv
// Round-robin arbiter for the rotation scheduler (purely combinational).
// Ports:
//   req_i       - request vector, one bit per requester
//   last_i      - index of the most recently granted requester
//   gnt_o       - one-hot grant (all zero when no request)
//   gnt_idx_o   - index of the granted requester
//   gnt_valid_o - high when some requester is granted
module rr_arbiter #(
   parameter int NREQ = 2
) (
   input  logic [NREQ-1:0]         req_i,
   input  logic [$clog2(NREQ)-1:0] last_i,
   output logic [NREQ-1:0]         gnt_o,
   output logic [$clog2(NREQ)-1:0] gnt_idx_o,
   output logic                    gnt_valid_o
);

   localparam int IDX_W = $clog2(NREQ);

   logic [IDX_W-1:0] cand_s;

   // Scan from the farthest candidate to the nearest after last_i, so the
   // nearest valid requester in cyclic order is the one left standing.
   always_comb begin
      gnt_o       = '0;
      gnt_idx_o   = '0;
      gnt_valid_o = 1'b0;
      cand_s      = '0;
      for (int k = NREQ; k >= 1; k--) begin
         cand_s = IDX_W'((int'(last_i) + k) % NREQ);
         if (req_i[cand_s]) begin
            gnt_o         = '0;
            gnt_o[cand_s] = 1'b1;
            gnt_idx_o     = cand_s;
            gnt_valid_o   = 1'b1;
         end else begin
            gnt_valid_o = gnt_valid_o;
         end
      end
   end

endmodule

// File: rtl/rot_job_sched.sv
// Scheduler sharing one image-rotation engine between NREQ requesters.
// Accepts jobs round-robin, starts the engine with the job's angle, maps the
// engine row/col address onto the image buffer and forwards the 784-pixel
// rotated stream tagged with its owner; a watchdog aborts a stalled engine.
// Ports:
//   clk_i, rst_ni                 - clock, async active-low reset
//   req_valid_i/req_ready_o       - per-requester job handshake (ready one-hot)
//   req_img_i/req_ang_i           - packed per-requester image index / angle
//   eng_start_o/eng_abort_o       - one-cycle engine control pulses
//   eng_ang_o                     - angle of the current job
//   eng_addr_i, eng_pix_valid_i, eng_pix_i - engine address and pixel stream
//   mem_addr_o                    - image buffer address {img, row, col}
//   out_valid_o/out_pix_o/out_last_o/out_owner_o - registered pixel stream
//   done_o, err_o, busy_o         - job complete (one-hot), timeout, busy
module rot_job_sched
   import rot_pkg::*;
#(
   parameter int NREQ    = 2,
   parameter int IMG_W   = 8,
   parameter int ANG_W   = 2,
   parameter int TIMEOUT = 64
) (
   input  logic                      clk_i,
   input  logic                      rst_ni,
   input  logic [NREQ-1:0]           req_valid_i,
   output logic [NREQ-1:0]           req_ready_o,
   input  logic [NREQ*IMG_W-1:0]     req_img_i,
   input  logic [NREQ*ANG_W-1:0]     req_ang_i,
   output logic                      eng_start_o,
   output logic                      eng_abort_o,
   output logic [ANG_W-1:0]          eng_ang_o,
   input  logic [ADDR_W-1:0]         eng_addr_i,
   input  logic                      eng_pix_valid_i,
   input  logic [PIX_W-1:0]          eng_pix_i,
   output logic [IMG_W+ADDR_W-1:0]   mem_addr_o,
   output logic                      out_valid_o,
   output logic [PIX_W-1:0]          out_pix_o,
   output logic                      out_last_o,
   output logic [$clog2(NREQ)-1:0]   out_owner_o,
   output logic [NREQ-1:0]           done_o,
   output logic                      err_o,
   output logic                      busy_o
);

   localparam int OWN_W = $clog2(NREQ);
   localparam int WD_W  = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0]  WD_MAX   = WD_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PIX_PER_IMG - 1);

   function automatic logic [NREQ-1:0] owner_onehot(input logic [OWN_W-1:0] idx);
      logic [NREQ-1:0] v;
      v      = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   sched_state_t     state_q, state_d;

   logic [NREQ-1:0]  gnt_s;
   logic [OWN_W-1:0] gnt_idx_s;
   logic             gnt_valid_s;

   logic [OWN_W-1:0] last_q;
   logic [OWN_W-1:0] owner_q;
   logic [IMG_W-1:0] img_q;
   logic [ANG_W-1:0] ang_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WD_W-1:0]  wd_q;

   logic             accept_s;
   logic             pix_take_s;
   logic             last_pix_s;
   logic             timeout_s;
   logic             cool_s;

   logic             start_q;
   logic             abort_q;
   logic             err_q;
   logic             out_valid_q;
   logic [PIX_W-1:0] out_pix_q;
   logic             out_last_q;
   logic [OWN_W-1:0] out_owner_q;
   logic [NREQ-1:0]  done_q;

   rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req_i       (req_valid_i),
      .last_i      (last_q),
      .gnt_o       (gnt_s),
      .gnt_idx_o   (gnt_idx_s),
      .gnt_valid_o (gnt_valid_s)
   );

   // The cycle in which done/err is presented is not an accept cycle; this
   // guarantees one idle cycle between back-to-back jobs.
   assign cool_s = (done_q != '0) || err_q;

   // Scheduler state register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and per-cycle control decode.
   always_comb begin
      state_d    = state_q;
      accept_s   = 1'b0;
      pix_take_s = 1'b0;
      last_pix_s = 1'b0;
      timeout_s  = 1'b0;
      case (state_q)
         IDLE: begin
            if (gnt_valid_s && !cool_s) begin
               accept_s = 1'b1;
               state_d  = START;
            end else begin
               state_d = IDLE;
            end
         end
         START: begin
            state_d = RUN;
         end
         RUN: begin
            // A pixel in the watchdog's final cycle takes precedence.
            if (eng_pix_valid_i) begin
               pix_take_s = 1'b1;
               if (cnt_q == CNT_LAST) begin
                  last_pix_s = 1'b1;
                  state_d    = IDLE;
               end else begin
                  state_d = RUN;
               end
            end else if (wd_q == WD_MAX) begin
               timeout_s = 1'b1;
               state_d   = IDLE;
            end else begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Job latch: image, angle, owner and round-robin pointer update on accept.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         img_q   <= '0;
         ang_q   <= '0;
         owner_q <= '0;
         last_q  <= OWN_W'(NREQ - 1);
      end else if (accept_s) begin
         img_q   <= req_img_i[gnt_idx_s*IMG_W +: IMG_W];
         ang_q   <= req_ang_i[gnt_idx_s*ANG_W +: ANG_W];
         owner_q <= gnt_idx_s;
         last_q  <= gnt_idx_s;
      end
   end

   // Pixel counter and saturating watchdog.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
         wd_q  <= '0;
      end else if (state_q == START) begin
         cnt_q <= '0;
         wd_q  <= '0;
      end else if (pix_take_s) begin
         cnt_q <= cnt_q + CNT_W'(1);
         wd_q  <= '0;
      end else if ((state_q == RUN) && (wd_q != WD_MAX)) begin
         wd_q <= wd_q + WD_W'(1);
      end
   end

   // Registered pulses and the forwarded pixel stream.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         start_q     <= 1'b0;
         abort_q     <= 1'b0;
         err_q       <= 1'b0;
         out_valid_q <= 1'b0;
         out_pix_q   <= '0;
         out_last_q  <= 1'b0;
         out_owner_q <= '0;
         done_q      <= '0;
      end else begin
         start_q     <= accept_s;
         abort_q     <= timeout_s;
         err_q       <= timeout_s;
         out_valid_q <= pix_take_s;
         out_last_q  <= last_pix_s;
         done_q      <= last_pix_s ? owner_onehot(owner_q) : '0;
         if (pix_take_s) begin
            out_pix_q   <= eng_pix_i;
            out_owner_q <= owner_q;
         end
      end
   end

   assign req_ready_o = accept_s ? gnt_s : '0;
   assign eng_start_o = start_q;
   assign eng_abort_o = abort_q;
   assign eng_ang_o   = ang_q;
   assign mem_addr_o  = {img_q, eng_addr_i};
   assign out_valid_o = out_valid_q;
   assign out_pix_o   = out_pix_q;
   assign out_last_o  = out_last_q;
   assign out_owner_o = out_owner_q;
   assign done_o      = done_q;
   assign err_o       = err_q;
   assign busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_rot_job_sched.sv
// Scoreboard bench for rot_job_sched: a driver plays requesters and engine,
// pushing expected grants, pixels and errors; a negedge monitor pops them.
module tb_rot_job_sched;

   localparam int NREQ    = 2;
   localparam int IMG_W   = 8;
   localparam int ANG_W   = 2;
   localparam int TIMEOUT = 64;
   localparam int ADDR_W  = 10;
   localparam int NPIX    = 784;

   logic                      clk_i = 1'b0;
   logic                      rst_ni = 1'b0;
   logic [NREQ-1:0]           req_valid_i;
   logic [NREQ-1:0]           req_ready_o;
   logic [NREQ*IMG_W-1:0]     req_img_i;
   logic [NREQ*ANG_W-1:0]     req_ang_i;
   logic                      eng_start_o;
   logic                      eng_abort_o;
   logic [ANG_W-1:0]          eng_ang_o;
   logic [ADDR_W-1:0]         eng_addr_i;
   logic                      eng_pix_valid_i;
   logic [7:0]                eng_pix_i;
   logic [IMG_W+ADDR_W-1:0]   mem_addr_o;
   logic                      out_valid_o;
   logic [7:0]                out_pix_o;
   logic                      out_last_o;
   logic [$clog2(NREQ)-1:0]   out_owner_o;
   logic [NREQ-1:0]           done_o;
   logic                      err_o;
   logic                      busy_o;

   rot_job_sched #(
      .NREQ(NREQ), .IMG_W(IMG_W), .ANG_W(ANG_W), .TIMEOUT(TIMEOUT)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_img_i(req_img_i), .req_ang_i(req_ang_i),
      .eng_start_o(eng_start_o), .eng_abort_o(eng_abort_o), .eng_ang_o(eng_ang_o),
      .eng_addr_i(eng_addr_i), .eng_pix_valid_i(eng_pix_valid_i), .eng_pix_i(eng_pix_i),
      .mem_addr_o(mem_addr_o),
      .out_valid_o(out_valid_o), .out_pix_o(out_pix_o), .out_last_o(out_last_o),
      .out_owner_o(out_owner_o),
      .done_o(done_o), .err_o(err_o), .busy_o(busy_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct { int g; int img; int ang; } gexp_t;
   typedef struct { int pix; bit last; int owner; } pexp_t;

   gexp_t gq[$];
   pexp_t pq[$];
   int    exp_err  = 0;
   int    total    = 0;
   int    bad      = 0;
   int    m_last   = NREQ - 1;   // model of the round-robin pointer
   bit    tight    = 1'b0;       // next grant must follow job end by exactly one cycle
   bit    have_end = 1'b0;
   int    end_cyc  = 0;

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference arbitration: first held request after the last grant, cyclically.
   function automatic int rr_pick();
      for (int k = 1; k <= NREQ; k++) begin
         if (req_valid_i[(m_last + k) % NREQ]) return (m_last + k) % NREQ;
      end
      return -1;
   endfunction

   // Monitor: pops expectations whenever the DUT presents something.
   initial begin : monitor
      gexp_t cur;
      pexp_t p;
      bit    prev_ready;
      cur = '{0, 0, 0};
      prev_ready = 1'b0;
      forever begin
         @(negedge clk_i);
         if (rst_ni) begin
            if (req_ready_o != '0) begin
               if (gq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_grant: got %b want none", req_ready_o);
               end else begin
                  cur = gq.pop_front();
                  chk("grant_onehot", req_ready_o, 1 << cur.g);
                  if (have_end && tight) chk("grant_gap", cyc - end_cyc, 1);
                  else if (have_end) chk("grant_after_end", cyc > end_cyc, 1);
               end
            end
            if (eng_start_o) begin
               chk("start_latency", prev_ready, 1);
               chk("start_ang", eng_ang_o, cur.ang);
               chk("start_img", mem_addr_o[ADDR_W +: IMG_W], cur.img);
            end
            prev_ready = (req_ready_o != '0);
            if (out_valid_o) begin
               if (pq.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_pixel: got %0d want none", out_pix_o);
               end else begin
                  p = pq.pop_front();
                  chk("pix", out_pix_o, p.pix);
                  chk("last", out_last_o, p.last);
                  chk("owner", out_owner_o, p.owner);
                  chk("done", done_o, p.last ? (1 << p.owner) : 0);
                  chk("ang_stable", eng_ang_o, cur.ang);
                  chk("img_stable", mem_addr_o[ADDR_W +: IMG_W], cur.img);
                  chk("addr_low", mem_addr_o[ADDR_W-1:0], eng_addr_i);
                  if (p.last) begin
                     have_end = 1'b1;
                     end_cyc  = cyc;
                  end
               end
            end else if (done_o != '0) begin
               total++; bad++;
               $display("FAIL unexpected_done: got %b want 0", done_o);
            end
            if (err_o || eng_abort_o) begin
               chk("err_abort_pair", {err_o, eng_abort_o}, 3);
               chk("err_expected", exp_err > 0, 1);
               if (exp_err > 0) exp_err--;
               have_end = 1'b1;
               end_cyc  = cyc;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         eng_addr_i = ADDR_W'($urandom);
         tick();
      end
   endtask

   task automatic drive_pix(input int owner, input bit last);
      int pix;
      pix = int'($urandom_range(0, 255));
      pq.push_back('{pix, last, owner});
      eng_pix_valid_i = 1'b1;
      eng_pix_i       = 8'(pix);
      eng_addr_i      = ADDR_W'($urandom);
      tick();
      eng_pix_valid_i = 1'b0;
   endtask

   // One job: mode 0 random short gaps, mode 1 watchdog-boundary gaps.
   // npix < NPIX without reset_mid means the engine stalls and must time out.
   task automatic job(input int npix, input int mode, input bit hold, input bit reset_mid);
      int g;
      bit started;
      g = rr_pick();
      if (g < 0) begin
         total++; bad++;
         $display("FAIL no_request: got none want a held request");
         return;
      end
      gq.push_back('{g, int'(req_img_i[g*IMG_W +: IMG_W]), int'(req_ang_i[g*ANG_W +: ANG_W])});
      m_last  = g;
      started = 1'b0;
      for (int w = 0; w < 40; w++) begin
         if (eng_start_o) begin
            started = 1'b1;
            break;
         end
         tick();
      end
      chk("start_seen", started, 1);
      if (!started) return;
      if (hold) begin
         req_img_i[g*IMG_W +: IMG_W] = IMG_W'($urandom);
         req_ang_i[g*ANG_W +: ANG_W] = ANG_W'($urandom);
      end else begin
         req_valid_i = '0;
      end
      // A pixel strobe in the START cycle must be ignored.
      eng_pix_valid_i = 1'b1;
      eng_pix_i       = 8'($urandom);
      tick();
      eng_pix_valid_i = 1'b0;
      for (int i = 0; i < npix; i++) begin
         if (mode == 1 && i < 30) idle(TIMEOUT - 1);
         else idle(int'($urandom_range(0, 2)));
         drive_pix(g, i == NPIX - 1);
      end
      if (reset_mid) begin
         @(negedge clk_i);
         #1;
         rst_ni      = 1'b0;
         req_valid_i = '0;
         tick();
         chk("rst_out_valid", out_valid_o, 0);
         chk("rst_out_pix", out_pix_o, 0);
         chk("rst_out_last", out_last_o, 0);
         chk("rst_out_owner", out_owner_o, 0);
         chk("rst_done", done_o, 0);
         chk("rst_err", {err_o, eng_abort_o, eng_start_o}, 0);
         chk("rst_busy", busy_o, 0);
         chk("rst_ang", eng_ang_o, 0);
         m_last   = NREQ - 1;
         have_end = 1'b0;
         tick();
         rst_ni = 1'b1;
         tick();
      end else if (npix < NPIX) begin
         exp_err++;
         for (int w = 0; w < TIMEOUT + 20; w++) begin
            tick();
            if (err_o) break;
         end
         chk("timeout_seen", err_o, 1);
      end
   endtask

   initial begin : global_bound
      #3_000_000;
      bad++;
      $display("FAIL global_timeout: got no end want end");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "time limit");
   end

   initial begin : driver
      req_valid_i     = '0;
      req_img_i       = '0;
      req_ang_i       = '0;
      eng_addr_i      = '0;
      eng_pix_valid_i = 1'b0;
      eng_pix_i       = '0;
      rst_ni          = 1'b0;
      repeat (3) tick();
      chk("reset_busy", busy_o, 0);
      chk("reset_outs", {out_valid_o, out_last_o, err_o, eng_abort_o, eng_start_o}, 0);
      chk("reset_done", done_o, 0);
      rst_ni = 1'b1;
      tick();

      // Contention from reset: both held, expected order 0,1,0,1.
      req_img_i   = NREQ*IMG_W'($urandom);
      req_ang_i   = NREQ*ANG_W'($urandom);
      req_valid_i = '1;
      job(NPIX, 0, 1'b1, 1'b0);
      tight = 1'b1;
      job(NPIX, 0, 1'b1, 1'b0);
      job(NPIX, 0, 1'b1, 1'b0);
      job(NPIX, 0, 1'b0, 1'b0);
      tight = 1'b0;
      idle(3);

      // Single job: requester 0, image 5, angle 1.
      req_img_i[0 +: IMG_W] = 8'd5;
      req_ang_i[0 +: ANG_W] = 2'd1;
      req_valid_i = 2'b01;
      job(NPIX, 0, 1'b0, 1'b0);

      // Stray engine strobes while idle are not forwarded.
      for (int i = 0; i < 20; i++) begin
         eng_pix_valid_i = 1'($urandom);
         eng_pix_i       = 8'($urandom);
         tick();
         chk("stray_no_out", out_valid_o, 0);
      end
      eng_pix_valid_i = 1'b0;

      // Timeout after 10 pixels; the other held request follows one cycle later.
      req_valid_i = '1;
      job(10, 0, 1'b1, 1'b0);
      tight = 1'b1;
      job(NPIX, 0, 1'b0, 1'b0);
      tight = 1'b0;
      idle(2);

      // Gaps of exactly TIMEOUT-1 idle cycles must not trip the watchdog.
      req_valid_i = 2'b10;
      job(NPIX, 1, 1'b0, 1'b0);
      idle(2);

      // Reset in the middle of a job, then normal operation resumes.
      req_valid_i = 2'b01;
      job(400, 0, 1'b0, 1'b1);
      req_valid_i = 2'b10;
      job(NPIX, 0, 1'b0, 1'b0);
      idle(2);
      req_valid_i = 2'b11;
      job(NPIX, 0, 1'b0, 1'b0);
      idle(5);

      chk("grant_queue_empty", gq.size(), 0);
      chk("pixel_queue_empty", pq.size(), 0);
      chk("err_queue_empty", exp_err, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rot_job_sched.md
# rot_job_sched

Scheduler that shares the single image-rotation engine between `NREQ` requesters (training loader, evaluation path, ...) in the edge augmentation pipeline. It arbitrates jobs round-robin, starts the engine with the job's angle, and maps the engine's row/column address onto the image buffer. It forwards the 784-pixel rotated stream tagged with its owner, and signals completion or a watchdog error per job.

## Interface
- `NREQ`, 2: number of requesters (2..8).
- `IMG_W`, 8: image index width; image buffer holds 2^IMG_W images of 28x28.
- `ANG_W`, 2: angle selector width passed to the engine.
- `TIMEOUT`, 64: max cycles between engine pixels before abort.
- `clk_i` in 1: clock.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in NREQ: job request per requester; held until accepted.
- `req_ready_o` out NREQ: one-hot accept pulse.
- `req_img_i` in NREQ*IMG_W: image index, slice k belongs to requester k.
- `req_ang_i` in NREQ*ANG_W: angle selector, slice k.
- `eng_start_o` out 1: one-cycle engine start pulse.
- `eng_abort_o` out 1: one-cycle engine abort pulse.
- `eng_ang_o` out ANG_W: latched angle, stable for the whole job.
- `eng_addr_i` in 10: engine address {row[4:0], col[4:0]}.
- `eng_pix_valid_i` in 1: engine pixel strobe.
- `eng_pix_i` in 8: engine pixel.
- `mem_addr_o` out IMG_W+10: {img_q, eng_addr_i}, combinational.
- `out_valid_o` out 1, `out_pix_o` out 8, `out_last_o` out 1, `out_owner_o` out $clog2(NREQ): registered pixel stream.
- `done_o` out NREQ: one-hot job-complete pulse.
- `err_o` out 1: one-cycle timeout pulse.
- `busy_o` out 1: high in any state except IDLE.

## Operation
- FSM states: IDLE, START, RUN.
- IDLE:
  - If any `req_valid_i` is high, grant g, the first valid requester after `last_q` in cyclic order.
  - Assert `req_ready_o[g]` in the same cycle.
  - Latch img, angle and owner.
  - Set `last_q`=g and go to START.
- START: `eng_start_o`=1 for exactly one cycle. Clear the pixel counter and watchdog, then go to RUN.
- RUN, on each `eng_pix_valid_i`:
  - Register the pixel onto `out_*` and increment `cnt_q` (10 bit, 0..783).
  - On the valid where `cnt_q`==783:
    - Assert `out_last_o` with that pixel.
    - Pulse `done_o[owner]` in the same cycle as the last `out_valid_o`.
    - Go to IDLE.
  - Valids arriving in IDLE or START are ignored and are not forwarded.
- Watchdog:
  - `wd_q` clears on every valid in RUN and increments otherwise.
  - When `wd_q` reaches TIMEOUT-1 with no valid: pulse `err_o` and `eng_abort_o`, do not pulse `done_o`, and go to IDLE.
  - If a valid arrives in the timeout cycle, the valid wins.
- Arbitration:
  - A requester dropping valid before it is granted is allowed.
  - Requests arriving during RUN wait; there is no preemption.
- Reset:
  - All outputs are 0, the FSM is in IDLE, and `last_q`=NREQ-1, so requester 0 has first priority.
  - Reset mid-job discards the job without `done_o` or `err_o`.
- Widths:
  - `cnt_q` is 10 bits.
  - `wd_q` is $clog2(TIMEOUT) bits and saturates.
  - The `mem_addr_o` concatenation is unsigned; there is no linear multiply.

## Timing
- Accept to `eng_start_o`: 1 cycle (accept in cycle n, start in n+1).
- `eng_pix_valid_i` to `out_valid_o`: 1 cycle, registered.
- `done_o` coincides with the final `out_valid_o`/`out_last_o`.
- The earliest next accept is the cycle after `done_o`/`err_o`, so there is 1 idle cycle between jobs.
- `eng_ang_o` and `mem_addr_o` high bits change only on accept.

## Structure
- Package `rot_pkg` holds:
  - `IMG_DIM`=28 and `PIX_PER_IMG`=784.
  - The state enum `sched_state_t` {IDLE, START, RUN}.
  - The address field widths (5-bit row/col).
- Sub-module `rr_arbiter` (parameter NREQ) takes the request vector and `last_q` and returns a one-hot grant and index, purely combinationally. `rot_job_sched` owns the FSM, counters, latches and output registers.

## Test plan
- Single job: req 0 with img=5, ang=1 → `req_ready_o`=01 in cycle n, `eng_start_o` in n+1, `eng_ang_o`=1, `mem_addr_o`[17:10]=5; feed 784 pixels → 784 `out_valid_o`, `out_last_o` on pixel 784, `done_o`=01, `out_owner_o`=0.
- Contention: both requesters hold valid from reset → grant order 0,1,0,1 across four jobs, `done_o` alternating.
- Timeout: after start, give 10 pixels, then none for 64 cycles → `err_o` and `eng_abort_o` pulse once, no `done_o`, next request accepted one cycle later.
- Watchdog boundary: pixel gaps of exactly 63 cycles → no error, job completes.
- Reset mid-RUN at pixel 400 → all outputs 0 next edge; a later req 1 completes normally and requester 0 keeps priority after reset.
- Stray valids in IDLE → `out_valid_o` stays 0.
